// File: rtl/div_pkg.sv
// Shared definitions for the signed/unsigned non-restoring divider: FSM state
// encoding, step-counter sizing and the minimum supported operand width.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } div_state_e;

    localparam int DIV_MIN_WIDTH = 4;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational non-restoring division iteration: shift the next dividend
// bit into the partial remainder, then add or subtract the divisor by its sign.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   part_rem,
    input  logic [WIDTH-1:0] part_quo,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH:0]   next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] sum_s;

    // Partial remainder stays in [-dvsr, dvsr), so WIDTH+2 bits hold 2r+bit.
    always_comb begin
        shifted_s = {part_rem, part_quo[WIDTH-1]};
        if (part_rem[WIDTH]) begin
            sum_s = shifted_s + {2'b00, dvsr};
        end else begin
            sum_s = shifted_s - {2'b00, dvsr};
        end
        next_rem = sum_s[WIDTH:0];
        next_quo = {part_quo[WIDTH-2:0], ~sum_s[WIDTH+1]};
    end

endmodule

// File: rtl/signed_divider_pipe.sv
// Iterative signed/unsigned divider (IDLE -> RUN x WIDTH -> FIX -> IDLE).
// Define DIVIDER_REMAINDER_EN to drive the corrected remainder; otherwise it is tied to 0.
module signed_divider_pipe
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [1:0]       ST_IDLE  = S_IDLE;
    localparam logic [1:0]       ST_RUN   = S_RUN;
    localparam logic [1:0]       ST_FIX   = S_FIX;
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH:0]   acc_rem_r;
    logic [WIDTH:0]   step_rem_s;
    logic [WIDTH-1:0] acc_quo_r;
    logic [WIDTH-1:0] step_quo_s;
    logic [WIDTH-1:0] dvsr_r;
    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dvs_mag_s;
    logic [WIDTH-1:0] quo_res_s;
    logic [WIDTH-1:0] quotient_r;
    logic             neg_q_r;
    logic             dbz_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;
    logic             div_by_zero_r;
    logic             overflow_r;
    logic             dvs_zero_s;
    logic             ovf_case_s;
    logic             last_step_s;
`ifdef DIVIDER_REMAINDER_EN
    logic             neg_r_r;
    logic [WIDTH-1:0] rem_fix_s;
    logic [WIDTH-1:0] rem_res_s;
    logic [WIDTH-1:0] remainder_r;
`endif

    // Operand magnitudes and special-case detection at the acceptance point.
    always_comb begin
        dvs_zero_s  = (divisor == ZERO_VAL);
        ovf_case_s  = signed_op && (dividend == MIN_VAL) && (divisor == ONES_VAL);
        last_step_s = (cnt_r == CNT_LAST);
        if (signed_op && dividend[WIDTH-1]) begin
            dvd_mag_s = ZERO_VAL - dividend;
        end else begin
            dvd_mag_s = dividend;
        end
        if (signed_op && divisor[WIDTH-1]) begin
            dvs_mag_s = ZERO_VAL - divisor;
        end else begin
            dvs_mag_s = divisor;
        end
    end

    // Next-state logic; a zero divisor skips RUN and goes straight to FIX.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = dvs_zero_s ? ST_FIX : ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                state_nx_s = last_step_s ? ST_FIX : ST_RUN;
            end
            ST_FIX: begin
                state_nx_s = (cnt_r == CNT_ZERO) ? ST_IDLE : ST_FIX;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .part_rem (acc_rem_r),
        .part_quo (acc_quo_r),
        .dvsr     (dvsr_r),
        .next_rem (step_rem_s),
        .next_quo (step_quo_s)
    );

    // Quotient sign restoration; MIN/-1 wraps back to MIN naturally.
    always_comb begin
        if (dbz_r) begin
            quo_res_s = ZERO_VAL;
        end else if (neg_q_r) begin
            quo_res_s = ZERO_VAL - acc_quo_r;
        end else begin
            quo_res_s = acc_quo_r;
        end
    end

`ifdef DIVIDER_REMAINDER_EN
    // Final remainder correction and sign restoration; on zero divisor the
    // untouched dividend is parked in the quotient register.
    always_comb begin
        if (acc_rem_r[WIDTH]) begin
            rem_fix_s = acc_rem_r[WIDTH-1:0] + dvsr_r;
        end else begin
            rem_fix_s = acc_rem_r[WIDTH-1:0];
        end
        if (dbz_r) begin
            rem_res_s = acc_quo_r;
        end else if (neg_r_r) begin
            rem_res_s = ZERO_VAL - rem_fix_s;
        end else begin
            rem_res_s = rem_fix_s;
        end
    end
`endif

    // Datapath, counter and registered result/flag outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            acc_rem_r     <= {(WIDTH+1){1'b0}};
            acc_quo_r     <= ZERO_VAL;
            dvsr_r        <= ZERO_VAL;
            neg_q_r       <= 1'b0;
            dbz_r         <= 1'b0;
            ovf_r         <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            quotient_r    <= ZERO_VAL;
            div_by_zero_r <= 1'b0;
            overflow_r    <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
            neg_r_r       <= 1'b0;
            remainder_r   <= ZERO_VAL;
`endif
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        neg_q_r   <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        dvsr_r    <= dvs_mag_s;
                        acc_rem_r <= {(WIDTH+1){1'b0}};
                        dbz_r     <= dvs_zero_s;
                        ovf_r     <= ovf_case_s;
`ifdef DIVIDER_REMAINDER_EN
                        neg_r_r   <= signed_op & dividend[WIDTH-1];
`endif
                        // Zero divisor holds FIX for two cycles to keep its fixed latency.
                        if (dvs_zero_s) begin
                            acc_quo_r <= dividend;
                            cnt_r     <= CNT_ONE;
                        end else begin
                            acc_quo_r <= dvd_mag_s;
                            cnt_r     <= CNT_ZERO;
                        end
                    end
                end
                ST_RUN: begin
                    acc_rem_r <= step_rem_s;
                    acc_quo_r <= step_quo_s;
                    cnt_r     <= last_step_s ? CNT_ZERO : (cnt_r + CNT_ONE);
                end
                ST_FIX: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        done_r        <= 1'b1;
                        quotient_r    <= quo_res_s;
                        div_by_zero_r <= dbz_r;
                        overflow_r    <= ovf_r;
`ifdef DIVIDER_REMAINDER_EN
                        remainder_r   <= rem_res_s;
`endif
                    end
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign div_by_zero = div_by_zero_r;
    assign overflow    = overflow_r;
`ifdef DIVIDER_REMAINDER_EN
    assign remainder   = remainder_r;
`else
    assign remainder   = ZERO_VAL;
`endif

endmodule

// File: tb/tb_signed_divider_pipe.sv
// Self-checking bench for signed_divider_pipe at WIDTH 32, 16 and 8 against a
// plain-arithmetic reference model; honours DIVIDER_REMAINDER_EN.
module tb_signed_divider_pipe;

`ifdef DIVIDER_REMAINDER_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32, st32, sg32, bz32, dn32, dz32, ov32;
    logic [31:0] a32, b32, q32, r32;
    logic        rst16, st16, sg16, bz16, dn16, dz16, ov16;
    logic [15:0] a16, b16, q16, r16;
    logic        rst8, st8, sg8, bz8, dn8, dz8, ov8;
    logic [7:0]  a8, b8, q8, r8;

    int n_chk = 0;
    int n_fail = 0;

    signed_divider_pipe #(.WIDTH(32)) dut32 (.clock(clk), .reset(rst32), .start(st32), .signed_op(sg32),
        .dividend(a32), .divisor(b32), .busy(bz32), .done(dn32), .quotient(q32), .remainder(r32),
        .div_by_zero(dz32), .overflow(ov32));
    signed_divider_pipe #(.WIDTH(16)) dut16 (.clock(clk), .reset(rst16), .start(st16), .signed_op(sg16),
        .dividend(a16), .divisor(b16), .busy(bz16), .done(dn16), .quotient(q16), .remainder(r16),
        .div_by_zero(dz16), .overflow(ov16));
    signed_divider_pipe #(.WIDTH(8)) dut8 (.clock(clk), .reset(rst8), .start(st8), .signed_op(sg8),
        .dividend(a8), .divisor(b8), .busy(bz8), .done(dn8), .quotient(q8), .remainder(r8),
        .div_by_zero(dz8), .overflow(ov8));

    task automatic drive(input int w, input logic s, input logic sg, input logic [63:0] a, input logic [63:0] b);
        case (w)
            32:      begin st32 = s; sg32 = sg; a32 = a[31:0]; b32 = b[31:0]; end
            16:      begin st16 = s; sg16 = sg; a16 = a[15:0]; b16 = b[15:0]; end
            default: begin st8 = s; sg8 = sg; a8 = a[7:0]; b8 = b[7:0]; end
        endcase
    endtask

    task automatic sample(input int w, output logic dn, output logic bz, output logic [63:0] q,
                          output logic [63:0] r, output logic dz, output logic ov);
        case (w)
            32:      begin dn = dn32; bz = bz32; q = {32'd0, q32}; r = {32'd0, r32}; dz = dz32; ov = ov32; end
            16:      begin dn = dn16; bz = bz16; q = {48'd0, q16}; r = {48'd0, r16}; dz = dz16; ov = ov16; end
            default: begin dn = dn8; bz = bz8; q = {56'd0, q8}; r = {56'd0, r8}; dz = dz8; ov = ov8; end
        endcase
    endtask

    // Reference: truncating division on sign-extended integers.
    task automatic model(input int w, input logic [63:0] a, input logic [63:0] b, input logic sg,
                         output logic [63:0] q, output logic [63:0] r, output logic dz, output logic ov);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bm;
        longint sa;
        longint sb;
        mask = (64'd1 << w) - 64'd1;
        am = a & mask;
        bm = b & mask;
        dz = (bm == 64'd0);
        ov = sg && (am == (64'd1 << (w - 1))) && (bm == mask);
        if (dz) begin
            q = 64'd0;
            r = am;
        end else if (sg) begin
            sa = $signed(am << (64 - w)) >>> (64 - w);
            sb = $signed(bm << (64 - w)) >>> (64 - w);
            q = 64'(sa / sb) & mask;
            r = 64'(sa % sb) & mask;
        end else begin
            q = am / bm;
            r = am % bm;
        end
        if (!REM_EN) r = 64'd0;
    endtask

    function automatic logic [63:0] pick(input int w, input bit is_div);
        logic [63:0] v;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = 64'd1 << (w - 1);
            2:       v = mask;
            3:       if (is_div) v = 64'($urandom_range(1, 9));
            default: v = v;
        endcase
        return v & mask;
    endfunction

    task automatic wait_done(input int w, inout int lat);
        logic dn, bz, dz, ov;
        logic [63:0] q, r;
        sample(w, dn, bz, q, r, dz, ov);
        while (!dn && lat < 200) begin
            @(negedge clk);
            lat++;
            sample(w, dn, bz, q, r, dz, ov);
        end
    endtask

    // Start one operation, scramble inputs after acceptance, wait for done.
    task automatic op(input int w, input logic [63:0] a, input logic [63:0] b, input logic sg, output int lat,
                      output logic [63:0] q, output logic [63:0] r, output logic dz, output logic ov);
        logic dn, bz;
        @(negedge clk);
        drive(w, 1'b1, sg, a, b);
        @(negedge clk);
        drive(w, 1'b0, ($urandom & 1) != 0, {$urandom, $urandom}, {$urandom, $urandom});
        lat = 0;
        wait_done(w, lat);
        sample(w, dn, bz, q, r, dz, ov);
    endtask

    task automatic test_reset;
        rst32 = 1'b0; rst16 = 1'b0; rst8 = 1'b0;
        drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(16, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
        #1;
        n_chk++; if (bz32 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bz32); end
        n_chk++; if (dn32 !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", dn32); end
        n_chk++; if (q32 !== 32'd0) begin n_fail++; $display("FAIL reset_q got=%h exp=0", q32); end
        n_chk++; if (r32 !== 32'd0) begin n_fail++; $display("FAIL reset_r got=%h exp=0", r32); end
        n_chk++; if ({dz32, ov32} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {dz32, ov32}); end
        @(negedge clk); @(negedge clk);
        rst32 = 1'b1; rst16 = 1'b1; rst8 = 1'b1;
    endtask

    task automatic test_directed32;
        logic [63:0] a [4] = '{64'd100, 64'hFFFF_FFF9, 64'd55, 64'h8000_0000};
        logic [63:0] b [4] = '{64'd7, 64'd2, 64'd0, 64'hFFFF_FFFF};
        logic        s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [63:0] eq [4] = '{64'd14, 64'hFFFF_FFFD, 64'd0, 64'h8000_0000};
        logic [63:0] er [4] = '{64'd2, 64'hFFFF_FFFF, 64'd55, 64'd0};
        int          el [4] = '{33, 33, 2, 33};
        logic [1:0]  ef [4] = '{2'b00, 2'b00, 2'b10, 2'b01};
        int lat;
        logic [63:0] q, r, rx;
        logic dz, ov;
        for (int i = 0; i < 4; i++) begin
            op(32, a[i], b[i], s[i], lat, q, r, dz, ov);
            rx = REM_EN ? er[i] : 64'd0;
            n_chk++; if (lat !== el[i]) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, el[i]); end
            n_chk++; if (q !== eq[i]) begin n_fail++; $display("FAIL dir%0d_q got=%h exp=%h", i, q, eq[i]); end
            n_chk++; if (r !== rx) begin n_fail++; $display("FAIL dir%0d_r got=%h exp=%h", i, r, rx); end
            n_chk++; if ({dz, ov} !== ef[i]) begin n_fail++; $display("FAIL dir%0d_flags got=%b exp=%b", i, {dz, ov}, ef[i]); end
        end
    endtask

    task automatic test_hold_and_clear;
        int lat;
        logic [63:0] q, r;
        logic dz, ov, dn, bz;
        op(32, 64'd100, 64'd7, 1'b0, lat, q, r, dz, ov);
        n_chk++; if ({dz, ov} !== 2'b00) begin n_fail++; $display("FAIL clear_flags got=%b exp=00", {dz, ov}); end
        repeat (3) @(negedge clk);
        sample(32, dn, bz, q, r, dz, ov);
        n_chk++; if (dn !== 1'b0) begin n_fail++; $display("FAIL hold_done got=%b exp=0", dn); end
        n_chk++; if (q !== 64'd14) begin n_fail++; $display("FAIL hold_q got=%h exp=e", q); end
    endtask

    task automatic test_busy_ignore;
        int lat;
        logic [63:0] q, r, rx;
        logic dz, ov, dn, bz;
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 64'd200, 64'd3);
        @(negedge clk);
        drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
        lat = 0;
        repeat (3) begin @(negedge clk); lat++; end
        drive(8, 1'b1, 1'b0, 64'd9, 64'd3);
        n_chk++; if (bz8 !== 1'b1) begin n_fail++; $display("FAIL ignore_busy got=%b exp=1", bz8); end
        @(negedge clk); lat++;
        drive(8, 1'b0, 1'b0, 64'd9, 64'd3);
        wait_done(8, lat);
        sample(8, dn, bz, q, r, dz, ov);
        rx = REM_EN ? 64'd2 : 64'd0;
        n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=9", lat); end
        n_chk++; if (q !== 64'd66) begin n_fail++; $display("FAIL ignore_q got=%0d exp=66", q); end
        n_chk++; if (r !== rx) begin n_fail++; $display("FAIL ignore_r got=%0d exp=%0d", r, rx); end
        drive(8, 1'b1, 1'b0, 64'd9, 64'd3);
        @(negedge clk);
        drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
        lat = 0;
        wait_done(8, lat);
        sample(8, dn, bz, q, r, dz, ov);
        n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=9", lat); end
        n_chk++; if (q !== 64'd3) begin n_fail++; $display("FAIL b2b_q got=%0d exp=3", q); end
        n_chk++; if (r !== 64'd0) begin n_fail++; $display("FAIL b2b_r got=%0d exp=0", r); end
    endtask

    task automatic test_back_to_back(input int n);
        logic [63:0] a, b, q, r, eq, er;
        logic sg, dz, ov, edz, eov, dn, bz;
        int lat;
        a = pick(8, 1'b0); b = pick(8, 1'b1); sg = ($urandom & 1) != 0;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            drive(8, 1'b1, sg, a, b);
            model(8, a, b, sg, eq, er, edz, eov);
            @(negedge clk);
            drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
            lat = 0;
            wait_done(8, lat);
            sample(8, dn, bz, q, r, dz, ov);
            n_chk++;
            if (q !== eq || r !== er || dz !== edz || ov !== eov || lat !== (edz ? 2 : 9)) begin
                n_fail++;
                $display("FAIL b2b%0d a=%h b=%h sg=%0d got q=%h r=%h f=%b lat=%0d exp q=%h r=%h f=%b",
                         i, a, b, sg, q, r, {dz, ov}, lat, eq, er, {edz, eov});
            end
            a = pick(8, 1'b0); b = pick(8, 1'b1); sg = ($urandom & 1) != 0;
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [63:0] q, r;
        logic dz, ov;
        bit saw_done;
        op(16, 64'd1000, 64'd10, 1'b0, lat, q, r, dz, ov);
        n_chk++; if (q !== 64'd100) begin n_fail++; $display("FAIL pre_abort_q got=%0d exp=100", q); end
        @(negedge clk);
        drive(16, 1'b1, 1'b0, 64'd1234, 64'd7);
        @(negedge clk);
        drive(16, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (4) @(negedge clk);
        rst16 = 1'b0;
        #1;
        n_chk++; if (bz16 !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", bz16); end
        n_chk++; if ({q16, r16, dz16, ov16} !== 34'd0) begin n_fail++; $display("FAIL abort_outputs q=%h r=%h f=%b exp=0", q16, r16, {dz16, ov16}); end
        saw_done = 1'b0;
        @(negedge clk);
        rst16 = 1'b1;
        repeat (25) begin @(negedge clk); if (dn16) saw_done = 1'b1; end
        n_chk++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got=%b exp=0", saw_done); end
        op(16, 64'd1000, 64'd10, 1'b0, lat, q, r, dz, ov);
        n_chk++; if (lat !== 17) begin n_fail++; $display("FAIL post_reset_latency got=%0d exp=17", lat); end
        n_chk++; if (q !== 64'd100) begin n_fail++; $display("FAIL post_reset_q got=%0d exp=100", q); end
        n_chk++; if (r !== 64'd0) begin n_fail++; $display("FAIL post_reset_r got=%0d exp=0", r); end
    endtask

    task automatic test_random(input int w, input int n);
        logic [63:0] a, b, q, r, eq, er;
        logic sg, dz, ov, edz, eov;
        int lat;
        for (int i = 0; i < n; i++) begin
            a = pick(w, 1'b0); b = pick(w, 1'b1); sg = ($urandom & 1) != 0;
            model(w, a, b, sg, eq, er, edz, eov);
            op(w, a, b, sg, lat, q, r, dz, ov);
            n_chk++;
            if (q !== eq || r !== er || dz !== edz || ov !== eov || lat !== (edz ? 2 : w + 1)) begin
                n_fail++;
                $display("FAIL rand_w%0d_%0d a=%h b=%h sg=%0d got q=%h r=%h f=%b lat=%0d exp q=%h r=%h f=%b",
                         w, i, a, b, sg, q, r, {dz, ov}, lat, eq, er, {edz, eov});
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed32;
        test_hold_and_clear;
        test_busy_ignore;
        test_back_to_back(30);
        test_reset_mid;
        test_random(32, 30);
        test_random(16, 20);
        test_random(8, 60);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
